// File: rtl/io_cfg_seq_if.sv
// Programming-side handshake bundle for io_cfg_seq.
//   cfg_start : request a (re)configuration
//   cfg_data  : serial direction bit
//   cfg_valid : cfg_data qualifier
//   cfg_ready : sequencer accepts a bit (SHIFT only)
//   cfg_busy  : sequence in progress
// The master modport is the programming interface; the slave modport is the sequencer.
interface io_cfg_seq_if;
  logic cfg_start;
  logic cfg_data;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_busy;

  modport master (
    output cfg_start,
    output cfg_data,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_busy
  );

  modport slave (
    input  cfg_start,
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready,
    output cfg_busy
  );
endinterface

// File: rtl/io_cfg_seq.sv
// I/O ring configuration sequencer.
// Isolates the pads, serially loads per-pad direction bits into a shadow register,
// commits them to fpga_dir together with config_done, then releases isolation
// after a guard interval.
// Ports:
//   prog_clk    : clock, rising edge
//   prog_rst_n  : asynchronous active-low reset
//   cfg         : handshake bundle (slave side)
//   config_done : pad CONFIG_DONE gate
//   io_isol_n   : pad isolation, 0 = isolated
//   fpga_dir    : per-pad direction, 1 = input, 0 = output
module io_cfg_seq #(
  parameter int unsigned NUM_IO       = 8,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  io_cfg_seq_if.slave       cfg,
  output logic              config_done,
  output logic              io_isol_n,
  output logic [NUM_IO-1:0] fpga_dir
);

  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned BW = $clog2(NUM_IO + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_IO - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    SHIFT,
    COMMIT,
    RELEASE,
    ACTIVE
  } state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     guard_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [NUM_IO-1:0] shadow;
  logic [NUM_IO-1:0] shadow_shifted;

  // First bit sent ends up in bit 0 after NUM_IO shifts.
  generate
    if (NUM_IO == 1) begin : g_shift1
      assign shadow_shifted = cfg.cfg_data;
    end else begin : g_shiftn
      assign shadow_shifted = {cfg.cfg_data, shadow[NUM_IO-1:1]};
    end
  endgenerate

  assign cfg.cfg_ready = (state == SHIFT);
  assign cfg.cfg_busy  = (state == ISOLATE) || (state == SHIFT) ||
                         (state == COMMIT)  || (state == RELEASE);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACTIVE: if (cfg.cfg_start) state_nxt = ISOLATE;
      ISOLATE:      if (guard_cnt == GUARD_LAST) state_nxt = SHIFT;
      SHIFT:        if (cfg.cfg_valid && (bit_cnt == BIT_LAST)) state_nxt = COMMIT;
      COMMIT:       state_nxt = RELEASE;
      RELEASE:      if (guard_cnt == GUARD_LAST) state_nxt = ACTIVE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Guard counter parks at its terminal value instead of incrementing past it,
  // so it never wraps regardless of width.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      config_done <= 1'b0;
      io_isol_n   <= 1'b0;
      fpga_dir    <= '1;
      shadow      <= '0;
      guard_cnt   <= '0;
      bit_cnt     <= '0;
    end else begin
      case (state)
        IDLE, ACTIVE: begin
          if (cfg.cfg_start) begin
            config_done <= 1'b0;
            io_isol_n   <= 1'b0;
            guard_cnt   <= '0;
          end
        end
        ISOLATE: begin
          if (guard_cnt == GUARD_LAST) begin
            bit_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        SHIFT: begin
          if (cfg.cfg_valid) begin
            shadow  <= shadow_shifted;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        COMMIT: begin
          fpga_dir    <= shadow;
          config_done <= 1'b1;
          guard_cnt   <= '0;
        end
        RELEASE: begin
          if (guard_cnt == GUARD_LAST) begin
            io_isol_n <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_cfg_seq.sv
module tb_io_cfg_seq;

  logic       prog_clk;
  logic       prog_rst_n;
  logic       config_done;
  logic       io_isol_n;
  logic [7:0] fpga_dir;

  int unsigned n_checks;
  int unsigned n_fail;

  io_cfg_seq_if cfg_bus ();

  io_cfg_seq #(
    .NUM_IO       (8),
    .GUARD_CYCLES (4)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_rst_n  (prog_rst_n),
    .cfg         (cfg_bus.slave),
    .config_done (config_done),
    .io_isol_n   (io_isol_n),
    .fpga_dir    (fpga_dir)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_dir"},   {24'd0, fpga_dir}, 32'hFF);
    check_eq({tag, "_done"},  {31'd0, config_done}, 32'd0);
    check_eq({tag, "_isol"},  {31'd0, io_isol_n}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, cfg_bus.cfg_ready}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, cfg_bus.cfg_busy}, 32'd0);
  endtask

  // Full load from IDLE/ACTIVE, entered and left at a negedge.
  // Slot k is the half-cycle after edge E+k. Stall window covers shift cycles
  // [stall_at, stall_at+stall_len). noise adds ignored cfg_valid in ISOLATE and
  // ignored cfg_start pulses during SHIFT and RELEASE.
  task automatic run_load(input string tag, input logic [7:0] data, input logic [7:0] old_dir,
                          input int stall_at, input int stall_len, input bit noise);
    int s;
    int j;
    int b;
    s = stall_len;
    cfg_bus.cfg_start = 1'b1;
    @(posedge prog_clk);
    for (int k = 0; k <= 19 + s; k++) begin
      @(negedge prog_clk);
      check_eq({tag, "_ready"}, {31'd0, cfg_bus.cfg_ready}, {31'd0, (k >= 4 && k <= 11 + s)});
      check_eq({tag, "_busy"},  {31'd0, cfg_bus.cfg_busy},  {31'd0, (k <= 16 + s)});
      check_eq({tag, "_done"},  {31'd0, config_done},       {31'd0, (k >= 13 + s)});
      check_eq({tag, "_isol"},  {31'd0, io_isol_n},         {31'd0, (k >= 17 + s)});
      check_eq({tag, "_dir"},   {24'd0, fpga_dir},          {24'd0, (k >= 13 + s) ? data : old_dir});
      check_eq({tag, "_inv"},   {31'd0, io_isol_n & ~config_done}, 32'd0);
      cfg_bus.cfg_start = noise && (k == 6 || k == 7 || k == 14 + s);
      j = k - 4;
      if (k < 4) begin
        cfg_bus.cfg_valid = noise;
        cfg_bus.cfg_data  = 1'b1;
      end else if (j < 8 + s) begin
        if (j >= stall_at && j < stall_at + s) begin
          cfg_bus.cfg_valid = 1'b0;
          cfg_bus.cfg_data  = 1'b1;
        end else begin
          b = (j < stall_at) ? j : j - s;
          cfg_bus.cfg_valid = 1'b1;
          cfg_bus.cfg_data  = data[b];
        end
      end else begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = 1'b0;
      end
    end
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abort_data;
    n_checks = 0;
    n_fail   = 0;
    prog_rst_n        = 1'b0;
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_data  = 1'b0;
    cfg_bus.cfg_valid = 1'b0;

    // 1. reset
    repeat (3) @(negedge prog_clk);
    check_reset_vals("rst_held");
    prog_rst_n = 1'b1;
    repeat (10) @(negedge prog_clk);
    check_reset_vals("rst_idle");

    // 2. nominal load
    run_load("nom", 8'hC5, 8'hFF, 0, 0, 1'b0);
    repeat (3) @(negedge prog_clk);
    check_eq("hold_dir",  {24'd0, fpga_dir}, 32'hC5);
    check_eq("hold_done", {31'd0, config_done}, 32'd1);
    check_eq("hold_isol", {31'd0, io_isol_n}, 32'd1);
    check_eq("hold_busy", {31'd0, cfg_bus.cfg_busy}, 32'd0);

    // 3. stalls plus ignored inputs
    run_load("stall", 8'hC5, 8'hC5, 3, 3, 1'b1);

    // 4. reconfiguration from ACTIVE
    repeat (2) @(negedge prog_clk);
    run_load("recfg", 8'h0F, 8'hC5, 0, 0, 1'b0);

    // 5. mid-shift reset after 5 accepted bits
    repeat (2) @(negedge prog_clk);
    abort_data = 8'hA5;
    cfg_bus.cfg_start = 1'b1;
    @(posedge prog_clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge prog_clk);
      cfg_bus.cfg_start = 1'b0;
      cfg_bus.cfg_valid = (k >= 4);
      cfg_bus.cfg_data  = (k >= 4) ? abort_data[k-4] : 1'b0;
    end
    @(negedge prog_clk);
    check_eq("abort_ready_pre", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    #2 prog_rst_n = 1'b0;
    #1;
    check_reset_vals("abort_async");
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = 1'b0;
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    check_reset_vals("abort_idle");
    run_load("reload", 8'h3C, 8'hFF, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
